icache: RTL and testbench
=========================

Name: icache

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch stage.
- Takes the PC (fetch `curr_addr`) and returns the instruction word and `imem_stall` in the same cycle on a hit.
- On a miss, stalls fetch and refills one line from the memory port with a word-by-word request/acknowledge handshake.
- Supports a whole-cache invalidate for FENCE.I.

Parameters:
- LINES, 16, number of cache lines; power of two, >= 2.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- addr  input  32  fetch address (fetch `curr_addr`); addr[1:0] ignored.
- instr  output  32  instruction to fetch `iinstr`; valid when imem_stall=0.
- imem_stall  output  1  to fetch `imem_stall`; 1 = instr not valid this cycle.
- flush  input  1  single-cycle pulse; invalidate all lines.
- mem_req  output  1  word read request to memory.
- mem_addr  output  32  word-aligned request address.
- mem_ack  input  1  memory returns mem_rdata this cycle.
- mem_rdata  input  32  read data, sampled when mem_req & mem_ack.

Behaviour:
- Address split:
  - OFF = log2(WORDS_PER_LINE) bits at addr[OFF+1:2].
  - IDX = log2(LINES) bits above OFF.
  - TAG = remaining upper bits.
- Storage: per line, valid bit, tag, data words. Register arrays with combinational read.
- Hit = state IDLE & valid[idx] & tag[idx]==addr tag & !flush_pending.
- instr and imem_stall are combinational from addr and state:
  - Hit: instr = data[idx][off], imem_stall=0.
  - Otherwise: imem_stall=1, instr=32'h00000013 (NOP).
- FSM states: IDLE, REFILL, FLUSH.
  - IDLE, flush=1 -> FLUSH. Flush has priority over miss.
  - IDLE, miss -> REFILL. Capture miss_tag/miss_idx from addr; word_cnt=0. imem_stall=1 in the detection cycle.
  - REFILL:
    - mem_req=1; mem_addr = {miss_tag, miss_idx, word_cnt, 2'b00}, held stable until mem_ack.
    - On mem_ack: write mem_rdata to data[miss_idx][word_cnt] and increment word_cnt.
    - mem_req stays 1 into the next word with no bubble cycle.
    - On ack of word WORDS_PER_LINE-1: write tag, set valid[miss_idx], go to IDLE (or FLUSH if flush_pending).
  - FLUSH: clear all valid bits and flush_pending, go to IDLE. One cycle, imem_stall=1.
- flush during REFILL sets flush_pending. The refill completes, then FLUSH runs. The refilled line ends invalid.
- flush in the FLUSH cycle is absorbed with no additional cycle.
- Refill always starts at word 0 (no critical-word-first).
- Refill uses the captured address; addr changes during REFILL are ignored. Lookup resumes in IDLE with the current addr.
- Miss penalty with zero-wait memory: detect cycle + WORDS_PER_LINE ack cycles. The hit is presented the cycle after the last ack.
- mem_ack while mem_req=0 is ignored.
- Reset (async, any time, including mid-refill):
  - State=IDLE, all valid=0, flush_pending=0, word_cnt=0.
  - mem_req=0 and mem_addr=0 immediately.
  - instr=NOP, imem_stall=1 (miss on the first lookup).
  - Data and tag arrays are not reset.
- Counters and indices wrap naturally at their widths. The word_cnt terminal value is WORDS_PER_LINE-1 and does not overflow.

Test Plan:
- Cold miss: reset, addr=0x100, memory returns 0xA0..0xA3 with ack every cycle.
  - mem_addr sequence 0x100,0x104,0x108,0x10C.
  - imem_stall=1 for 5 cycles, then instr=0xA0 with stall=0.
  - addr=0x108 next cycle -> instr=0xA2, hit, no mem_req.
- Wait states: same refill with ack after 3 idle cycles per word -> mem_addr held constant until each ack, data written only on ack, mem_req continuous.
- Conflict eviction: fill 0x100, then access 0x100+LINES*16=0x200 -> refill, tag replaced; re-access 0x100 -> miss again.
- Flush: line 0x100 valid, pulse flush in IDLE -> one FLUSH stall cycle, then 0x100 misses. Flush mid-refill -> refill completes all 4 acks, then FLUSH cycle, line invalid.
- Reset mid-refill: assert rst after 2 acks -> mem_req=0 asynchronously. After release, addr=0x100 misses and refill restarts at word 0 (mem_addr=0x100).
- Back-to-back: hits at 0x100,0x104,0x108,0x10C on consecutive cycles -> stall=0 every cycle, correct words returned.

Source files
------------

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache sitting in front of fetch.
// Hits answer combinationally; misses refill a whole line word by word over a req/ack port.
module icache #(
  parameter int LINES          = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  output logic [31:0] instr,
  output logic        imem_stall,
  input  logic        flush,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [31:0]      NOP       = 32'h0000_0013;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(WORDS_PER_LINE - 1);

  typedef enum logic [1:0] {IDLE, REFILL, FLUSH} state_t;

  state_t           state_q, state_d;
  logic [LINES-1:0] valid_q;
  logic             flush_pending_q;
  logic [OFF_W-1:0] word_cnt_q;
  logic [TAG_W-1:0] miss_tag_q;
  logic [IDX_W-1:0] miss_idx_q;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WORDS_PER_LINE];

  logic [OFF_W-1:0] addr_off;
  logic [IDX_W-1:0] addr_idx;
  logic [TAG_W-1:0] addr_tag;
  logic             hit;
  logic             ack_fire;
  logic             last_ack;
  logic             start_refill;

  assign addr_off = addr[OFF_W+1:2];
  assign addr_idx = addr[IDX_W+OFF_W+1:OFF_W+2];
  assign addr_tag = addr[31:IDX_W+OFF_W+2];

  assign hit = (state_q == IDLE) && valid_q[addr_idx] &&
               (tag_mem[addr_idx] == addr_tag) && !flush_pending_q;
  assign ack_fire     = (state_q == REFILL) && mem_ack;
  assign last_ack     = ack_fire && (word_cnt_q == LAST_WORD);
  assign start_refill = (state_q == IDLE) && !flush && !hit;

  always_comb begin
    state_d    = state_q;
    instr      = NOP;
    imem_stall = 1'b1;
    mem_req    = 1'b0;
    mem_addr   = '0;
    case (state_q)
      IDLE: begin
        if (hit) begin
          instr      = data_mem[addr_idx][addr_off];
          imem_stall = 1'b0;
        end
        // A flush outranks a miss in the same cycle.
        if (flush) state_d = FLUSH;
        else if (!hit) state_d = REFILL;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {miss_tag_q, miss_idx_q, word_cnt_q, 2'b00};
        if (last_ack) state_d = (flush_pending_q || flush) ? FLUSH : IDLE;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      flush_pending_q <= 1'b0;
      word_cnt_q      <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (start_refill) word_cnt_q <= '0;
        REFILL: begin
          if (ack_fire) word_cnt_q <= word_cnt_q + OFF_W'(1);
          if (flush) flush_pending_q <= 1'b1;
          if (last_ack) valid_q[miss_idx_q] <= 1'b1;
        end
        FLUSH: begin
          valid_q         <= '0;
          flush_pending_q <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage and the captured miss address carry no reset.
  always_ff @(posedge clk) begin
    if (start_refill) begin
      miss_tag_q <= addr_tag;
      miss_idx_q <= addr_idx;
    end
    if (ack_fire) data_mem[miss_idx_q][word_cnt_q] <= mem_rdata;
    if (last_ack) tag_mem[miss_idx_q] <= miss_tag_q;
  end

endmodule

// File: tb/tb_icache.sv
// Bench for icache: behavioural memory responder plus scenario tasks that compare
// observed refill addresses and fetched words against bench-computed expectations.
module tb_icache;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk, rst, flush, imem_stall, mem_req, mem_ack;
  logic [31:0] addr, instr, mem_addr, mem_rdata;

  int compared   = 0;
  int mismatched = 0;
  int mem_wait   = 0;
  int wait_cnt   = 0;
  bit spur_ack   = 1'b0;

  logic [31:0] exp_addr_q[$];
  logic [31:0] obs_addr_q[$];
  logic [31:0] exp_instr_q[$];

  icache #(.LINES(16), .WORDS_PER_LINE(4)) dut (
    .clk(clk), .rst(rst), .addr(addr), .instr(instr), .imem_stall(imem_stall),
    .flush(flush), .mem_req(mem_req), .mem_addr(mem_addr),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hA0 + (a >> 2) - 32'h40;
  endfunction

  // Memory: records each accepted word, then answers after mem_wait idle cycles.
  always @(posedge clk) begin
    if (!rst && mem_req && mem_ack) obs_addr_q.push_back(mem_addr);
    #1;
    if (mem_req) begin
      if (wait_cnt >= mem_wait) begin
        mem_ack   = 1'b1;
        mem_rdata = mem_word(mem_addr);
        wait_cnt  = 0;
      end else begin
        mem_ack   = 1'b0;
        mem_rdata = 32'hDEAD_BEEF;
        wait_cnt++;
      end
    end else begin
      mem_ack   = spur_ack;
      mem_rdata = 32'hBAD0_0000;
      wait_cnt  = 0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr_q.push_back(base + 32'(4 * i));
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; addr = 32'h100; mem_ack = 1'b0; mem_rdata = '0;
    @(posedge clk);
    @(negedge clk);
    compared++; if (imem_stall !== 1'b1) begin mismatched++; $display("FAIL reset_stall got=%b exp=1", imem_stall); end
    compared++; if (instr !== NOP) begin mismatched++; $display("FAIL reset_instr got=%h exp=%h", instr, NOP); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL reset_req got=%b exp=0", mem_req); end
    compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL reset_maddr got=%h exp=0", mem_addr); end
    step();
    rst = 1'b0;
  endtask

  task automatic test_cold_miss();
    int n;
    push_line(32'h100);
    n = 0;
    @(negedge clk);
    while (imem_stall === 1'b1 && n < 50) begin n++; @(negedge clk); end
    compared++; if (n !== 5) begin mismatched++; $display("FAIL cold_stall_cycles got=%0d exp=5", n); end
    compared++; if (instr !== 32'hA0) begin mismatched++; $display("FAIL cold_instr got=%h exp=a0", instr); end
    compared++; if (obs_addr_q.size() !== exp_addr_q.size()) begin mismatched++; $display("FAIL cold_nreq got=%0d exp=%0d", obs_addr_q.size(), exp_addr_q.size()); end
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_addr_q.pop_front(); e = exp_addr_q.pop_front();
      compared++; if (o !== e) begin mismatched++; $display("FAIL cold_maddr got=%h exp=%h", o, e); end
    end
    obs_addr_q.delete(); exp_addr_q.delete();
    step();
    addr = 32'h108;
    @(negedge clk);
    compared++; if (imem_stall !== 1'b0) begin mismatched++; $display("FAIL cold_hit_stall got=%b exp=0", imem_stall); end
    compared++; if (instr !== 32'hA2) begin mismatched++; $display("FAIL cold_hit_instr got=%h exp=a2", instr); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL cold_hit_req got=%b exp=0", mem_req); end
  endtask

  task automatic test_back_to_back();
    spur_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] e;
      step();
      addr = 32'h100 + 32'(4 * i);
      exp_instr_q.push_back(mem_word(addr));
      @(negedge clk);
      e = exp_instr_q.pop_front();
      compared++; if (imem_stall !== 1'b0) begin mismatched++; $display("FAIL b2b_stall[%0d] got=%b exp=0", i, imem_stall); end
      compared++; if (instr !== e) begin mismatched++; $display("FAIL b2b_instr[%0d] got=%h exp=%h", i, instr, e); end
      compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL b2b_req[%0d] got=%b exp=0", i, mem_req); end
    end
    spur_ack = 1'b0;
  endtask

  task automatic test_flush_idle();
    int n;
    step();
    addr = 32'h100; flush = 1'b1;
    @(negedge clk);
    step();
    @(negedge clk);
    compared++; if (imem_stall !== 1'b1) begin mismatched++; $display("FAIL flush_cycle_stall got=%b exp=1", imem_stall); end
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL flush_cycle_req got=%b exp=0", mem_req); end
    step();
    flush = 1'b0;
    push_line(32'h100);
    n = 0;
    @(negedge clk);
    while (imem_stall === 1'b1 && n < 50) begin n++; @(negedge clk); end
    compared++; if (n !== 5) begin mismatched++; $display("FAIL flush_remiss_cycles got=%0d exp=5", n); end
    compared++; if (instr !== 32'hA0) begin mismatched++; $display("FAIL flush_instr got=%h exp=a0", instr); end
    compared++; if (obs_addr_q.size() !== exp_addr_q.size()) begin mismatched++; $display("FAIL flush_nreq got=%0d exp=%0d", obs_addr_q.size(), exp_addr_q.size()); end
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_addr_q.pop_front(); e = exp_addr_q.pop_front();
      compared++; if (o !== e) begin mismatched++; $display("FAIL flush_maddr got=%h exp=%h", o, e); end
    end
    obs_addr_q.delete(); exp_addr_q.delete();
  endtask

  task automatic test_wait_states();
    int n;
    step();
    flush = 1'b1; addr = 32'h100;
    @(negedge clk);
    step();
    flush = 1'b0; mem_wait = 3;
    push_line(32'h100);
    n = 0;
    @(negedge clk);
    while (imem_stall === 1'b1 && n < 200) begin
      if (n >= 2) begin
        compared++; if (mem_req !== 1'b1) begin mismatched++; $display("FAIL wait_req[%0d] got=%b exp=1", n, mem_req); end
        compared++;
        if (mem_addr !== 32'h100 + 32'(4 * obs_addr_q.size())) begin
          mismatched++;
          $display("FAIL wait_maddr[%0d] got=%h exp=%h", n, mem_addr, 32'h100 + 32'(4 * obs_addr_q.size()));
        end
      end
      n++;
      @(negedge clk);
    end
    mem_wait = 0;
    compared++; if (n !== 18) begin mismatched++; $display("FAIL wait_stall_cycles got=%0d exp=18", n); end
    compared++; if (obs_addr_q.size() !== exp_addr_q.size()) begin mismatched++; $display("FAIL wait_nreq got=%0d exp=%0d", obs_addr_q.size(), exp_addr_q.size()); end
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_addr_q.pop_front(); e = exp_addr_q.pop_front();
      compared++; if (o !== e) begin mismatched++; $display("FAIL wait_ack_maddr got=%h exp=%h", o, e); end
    end
    obs_addr_q.delete(); exp_addr_q.delete();
    for (int i = 0; i < 4; i++) begin
      step();
      addr = 32'h100 + 32'(4 * i);
      @(negedge clk);
      compared++;
      if (imem_stall !== 1'b0 || instr !== mem_word(addr)) begin
        mismatched++;
        $display("FAIL wait_data[%0d] got=%h/%b exp=%h/0", i, instr, imem_stall, mem_word(addr));
      end
    end
  endtask

  task automatic test_conflict();
    logic [31:0] bases [2];
    bases[0] = 32'h200; bases[1] = 32'h100;
    for (int k = 0; k < 2; k++) begin
      int n;
      step();
      addr = bases[k];
      push_line(bases[k]);
      n = 0;
      @(negedge clk);
      while (imem_stall === 1'b1 && n < 50) begin n++; @(negedge clk); end
      compared++; if (n !== 5) begin mismatched++; $display("FAIL conflict_cycles[%0d] got=%0d exp=5", k, n); end
      compared++; if (instr !== mem_word(bases[k])) begin mismatched++; $display("FAIL conflict_instr[%0d] got=%h exp=%h", k, instr, mem_word(bases[k])); end
      compared++; if (obs_addr_q.size() !== exp_addr_q.size()) begin mismatched++; $display("FAIL conflict_nreq[%0d] got=%0d exp=%0d", k, obs_addr_q.size(), exp_addr_q.size()); end
      while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
        logic [31:0] o, e;
        o = obs_addr_q.pop_front(); e = exp_addr_q.pop_front();
        compared++; if (o !== e) begin mismatched++; $display("FAIL conflict_maddr got=%h exp=%h", o, e); end
      end
      obs_addr_q.delete(); exp_addr_q.delete();
    end
  endtask

  task automatic test_flush_mid_refill();
    int n;
    step();
    addr = 32'h300;
    push_line(32'h300);
    push_line(32'h300);
    n = 0;
    forever begin
      @(negedge clk);
      if (imem_stall !== 1'b1 || n >= 60) break;
      if (n == 5 || n == 6) begin
        compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL midflush_req[%0d] got=%b exp=0", n, mem_req); end
      end
      n++;
      step();
      flush = (n == 2);
    end
    flush = 1'b0;
    compared++; if (n !== 11) begin mismatched++; $display("FAIL midflush_cycles got=%0d exp=11", n); end
    compared++; if (instr !== 32'h120) begin mismatched++; $display("FAIL midflush_instr got=%h exp=120", instr); end
    compared++; if (obs_addr_q.size() !== exp_addr_q.size()) begin mismatched++; $display("FAIL midflush_nreq got=%0d exp=%0d", obs_addr_q.size(), exp_addr_q.size()); end
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_addr_q.pop_front(); e = exp_addr_q.pop_front();
      compared++; if (o !== e) begin mismatched++; $display("FAIL midflush_maddr got=%h exp=%h", o, e); end
    end
    obs_addr_q.delete(); exp_addr_q.delete();
  endtask

  task automatic test_reset_mid_refill();
    int n;
    step();
    addr = 32'h100;
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h104);
    step();
    step();
    step();
    compared++; if (mem_req !== 1'b1 || mem_addr !== 32'h108) begin mismatched++; $display("FAIL rstmid_pre got=%b/%h exp=1/108", mem_req, mem_addr); end
    rst = 1'b1;
    #1;
    compared++; if (mem_req !== 1'b0) begin mismatched++; $display("FAIL rstmid_req got=%b exp=0", mem_req); end
    compared++; if (mem_addr !== 32'h0) begin mismatched++; $display("FAIL rstmid_maddr got=%h exp=0", mem_addr); end
    compared++; if (imem_stall !== 1'b1 || instr !== NOP) begin mismatched++; $display("FAIL rstmid_out got=%h/%b exp=%h/1", instr, imem_stall, NOP); end
    compared++; if (obs_addr_q.size() !== exp_addr_q.size()) begin mismatched++; $display("FAIL rstmid_nreq got=%0d exp=%0d", obs_addr_q.size(), exp_addr_q.size()); end
    obs_addr_q.delete(); exp_addr_q.delete();
    step();
    step();
    rst = 1'b0;
    push_line(32'h100);
    n = 0;
    @(negedge clk);
    while (imem_stall === 1'b1 && n < 50) begin n++; @(negedge clk); end
    compared++; if (n !== 5) begin mismatched++; $display("FAIL rstmid_cycles got=%0d exp=5", n); end
    compared++; if (instr !== 32'hA0) begin mismatched++; $display("FAIL rstmid_instr got=%h exp=a0", instr); end
    compared++; if (obs_addr_q.size() !== exp_addr_q.size()) begin mismatched++; $display("FAIL rstmid_renreq got=%0d exp=%0d", obs_addr_q.size(), exp_addr_q.size()); end
    while (obs_addr_q.size() > 0 && exp_addr_q.size() > 0) begin
      logic [31:0] o, e;
      o = obs_addr_q.pop_front(); e = exp_addr_q.pop_front();
      compared++; if (o !== e) begin mismatched++; $display("FAIL rstmid_maddr got=%h exp=%h", o, e); end
    end
    obs_addr_q.delete(); exp_addr_q.delete();
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_flush_idle();
    test_wait_states();
    test_conflict();
    test_flush_mid_refill();
    test_reset_mid_refill();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
